// File: rtl/ecap5_dproc_pkg.sv
// ---------------------------------------------------------------------------
// ecap5_dproc_pkg
// Shared definitions for the ecap5 dproc front end:
//   - fixed architectural addresses (boot, interrupt, debug entry)
//   - pc_gen state encoding
//   - redirect-cause encoding, ordered so that a larger value wins arbitration
//   - small arithmetic helper for sequential fetch
// ---------------------------------------------------------------------------
package ecap5_dproc_pkg;

    localparam logic [31:0] boot_address      = 32'h0000_0000;
    localparam logic [31:0] interrupt_address = 32'hFF00_000A;
    localparam logic [31:0] debug_address     = 32'hFF00_000B;

    typedef enum logic [1:0] {
        STATE_BOOT  = 2'd0,
        STATE_RUN   = 2'd1,
        STATE_DEBUG = 2'd2
    } pc_gen_state_t;

    // Numeric order is the arbitration order. DEBUG and DRET can never
    // compete (DEBUG only from RUN, DRET only from DEBUG), so a single
    // linear order covers both states.
    typedef enum logic [2:0] {
        CAUSE_NONE   = 3'd0,
        CAUSE_BRANCH = 3'd1,
        CAUSE_IRQ    = 3'd2,
        CAUSE_DEBUG  = 3'd3,
        CAUSE_DRET   = 3'd4
    } redirect_cause_t;

    // Next sequential fetch address; wraps modulo 2^32.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// ---------------------------------------------------------------------------
// pc_gen_if
// Fetch request handshake between pc_gen (master) and the fetch stage (slave).
//   valid_o : pc_o holds a fetch request      (master -> slave)
//   pc_o    : fetch address, 32 bits          (master -> slave)
//   ready_i : fetch stage accepts the request (slave  -> master)
// A transfer completes on a cycle where valid_o and ready_i are both 1.
// ---------------------------------------------------------------------------
interface pc_gen_if;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;

    modport master (output valid_o, output pc_o, input ready_i);
    modport slave  (input valid_o, input pc_o, output ready_i);
endinterface

// File: rtl/pc_redirect_arb.sv
// ---------------------------------------------------------------------------
// pc_redirect_arb
// Chooses which redirect (if any) pc_gen applies this cycle and maintains the
// single-entry pending slot used while a request is stalled.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   state              : current pc_gen state (events only count in RUN/DEBUG)
//   hold               : request presented but not accepted this cycle
//   branch_i/_target_i : branch redirect pulse and target
//   irq_i              : interrupt level (RUN only)
//   drq_i              : debug request level (RUN only, debug build)
//   dret_i/_target_i   : debug return pulse and resume address (debug build)
//   apply_cause/target : redirect to load into pc on the next edge
// Build option: ECAP5_DPROC_DEBUG_EN enables drq_i/dret_i handling.
// ---------------------------------------------------------------------------
module pc_redirect_arb
    import ecap5_dproc_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  pc_gen_state_t   state,
    input  logic            hold,
    input  logic            branch_i,
    input  logic [31:0]     branch_target_i,
    input  logic            irq_i,
    input  logic            drq_i,
    input  logic            dret_i,
    input  logic [31:0]     dret_target_i,
    output redirect_cause_t apply_cause,
    output logic [31:0]     apply_target
);

    redirect_cause_t new_cause_s;
    logic [31:0]     new_target_s;
    redirect_cause_t best_cause_s;
    logic [31:0]     best_target_s;
    redirect_cause_t pend_cause_next_s;
    logic [31:0]     pend_target_next_s;
    redirect_cause_t pend_cause_r;
    logic [31:0]     pend_target_r;

    // Low address bits are dropped by alignment; debug inputs are unused in
    // the default build.
    logic unused_s;
    assign unused_s = ^{branch_target_i[1:0], dret_target_i, drq_i, dret_i};

    // Highest-priority event arriving this cycle for the current state.
    always_comb begin
        new_cause_s  = CAUSE_NONE;
        new_target_s = 32'h0000_0000;
        case (state)
            STATE_RUN: begin
`ifdef ECAP5_DPROC_DEBUG_EN
                if (drq_i) begin
                    new_cause_s  = CAUSE_DEBUG;
                    new_target_s = debug_address;
                end else
`endif
                if (irq_i) begin
                    new_cause_s  = CAUSE_IRQ;
                    new_target_s = interrupt_address;
                end else if (branch_i) begin
                    new_cause_s  = CAUSE_BRANCH;
                    new_target_s = {branch_target_i[31:2], 2'b00};
                end else begin
                    new_cause_s  = CAUSE_NONE;
                    new_target_s = 32'h0000_0000;
                end
            end
`ifdef ECAP5_DPROC_DEBUG_EN
            STATE_DEBUG: begin
                if (dret_i) begin
                    new_cause_s  = CAUSE_DRET;
                    new_target_s = {dret_target_i[31:2], 2'b00};
                end else if (branch_i) begin
                    new_cause_s  = CAUSE_BRANCH;
                    new_target_s = {branch_target_i[31:2], 2'b00};
                end else begin
                    new_cause_s  = CAUSE_NONE;
                    new_target_s = 32'h0000_0000;
                end
            end
`endif
            default: begin
                new_cause_s  = CAUSE_NONE;
                new_target_s = 32'h0000_0000;
            end
        endcase
    end

    // A new event displaces the pending one only at equal or higher
    // priority; equal priority means the later event wins.
    always_comb begin
        best_cause_s  = pend_cause_r;
        best_target_s = pend_target_r;
        if ((new_cause_s != CAUSE_NONE) && (new_cause_s >= pend_cause_r)) begin
            best_cause_s  = new_cause_s;
            best_target_s = new_target_s;
        end else begin
            best_cause_s  = pend_cause_r;
            best_target_s = pend_target_r;
        end
    end

    // While stalled the winner parks in the slot; otherwise it is applied.
    always_comb begin
        apply_cause        = CAUSE_NONE;
        apply_target       = 32'h0000_0000;
        pend_cause_next_s  = CAUSE_NONE;
        pend_target_next_s = 32'h0000_0000;
        if (hold) begin
            pend_cause_next_s  = best_cause_s;
            pend_target_next_s = best_target_s;
        end else begin
            apply_cause  = best_cause_s;
            apply_target = best_target_s;
        end
    end

    // Pending redirect slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_cause_r  <= CAUSE_NONE;
            pend_target_r <= 32'h0000_0000;
        end else begin
            pend_cause_r  <= pend_cause_next_s;
            pend_target_r <= pend_target_next_s;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen
// Program-counter generator: waits BOOT_DELAY cycles after reset, then issues
// fetch requests starting at boot_address, stepping by 4 per accepted request
// and honouring branch / interrupt / debug redirects.
// Parameters:
//   BOOT_DELAY : cycles spent in BOOT after reset release (default 2)
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   branch_i, branch_target_i
//   irq_i, drq_i            : interrupt / debug request levels
//   dret_i, dret_target_i   : debug return pulse and resume address
//   fetch                   : pc_gen_if.master (valid_o, ready_i, pc_o)
// Build option: define ECAP5_DPROC_DEBUG_EN to include the DEBUG state with
// drq_i and dret_i handling; without it those inputs are ignored.
// ---------------------------------------------------------------------------
module pc_gen
    import ecap5_dproc_pkg::*;
#(
    parameter int BOOT_DELAY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        irq_i,
    input  logic        drq_i,
    input  logic        dret_i,
    input  logic [31:0] dret_target_i,
    pc_gen_if.master    fetch
);

    // A zero delay behaves like a single boot cycle.
    localparam int CNT_W    = (BOOT_DELAY > 1) ? $clog2(BOOT_DELAY) : 1;
    localparam int LAST_INT = (BOOT_DELAY > 0) ? (BOOT_DELAY - 1) : 0;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST_INT);

    pc_gen_state_t   state_r;
    logic [CNT_W-1:0] cnt_r;
    logic            valid_r;
    logic [31:0]     pc_r;
    logic            hold_s;
    logic            xfer_s;
    redirect_cause_t apply_cause_s;
    logic [31:0]     apply_target_s;

    assign fetch.valid_o = valid_r;
    assign fetch.pc_o    = pc_r;
    assign hold_s        = valid_r & ~fetch.ready_i;
    assign xfer_s        = valid_r & fetch.ready_i;

    pc_redirect_arb u_arb (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .state           (state_r),
        .hold            (hold_s),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .irq_i           (irq_i),
        .drq_i           (drq_i),
        .dret_i          (dret_i),
        .dret_target_i   (dret_target_i),
        .apply_cause     (apply_cause_s),
        .apply_target    (apply_target_s)
    );

    // Main FSM with registered request outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= STATE_BOOT;
            cnt_r   <= {CNT_W{1'b0}};
            valid_r <= 1'b0;
            pc_r    <= boot_address;
        end else begin
            case (state_r)
                STATE_BOOT: begin
                    pc_r <= boot_address;
                    if (cnt_r == LAST_CNT) begin
                        state_r <= STATE_RUN;
                        cnt_r   <= {CNT_W{1'b0}};
                        valid_r <= 1'b1;
                    end else begin
                        state_r <= STATE_BOOT;
                        cnt_r   <= cnt_r + CNT_W'(32'd1);
                        valid_r <= 1'b0;
                    end
                end
                STATE_RUN,
                STATE_DEBUG: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (apply_cause_s != CAUSE_NONE) begin
                        pc_r    <= apply_target_s;
                        valid_r <= 1'b1;
                        if (apply_cause_s == CAUSE_DEBUG) begin
                            state_r <= STATE_DEBUG;
                        end else if (apply_cause_s == CAUSE_DRET) begin
                            state_r <= STATE_RUN;
                        end else begin
                            state_r <= state_r;
                        end
                    end else if (xfer_s) begin
                        pc_r    <= next_seq_pc(pc_r);
                        valid_r <= 1'b1;
                        state_r <= state_r;
                    end else begin
                        // Stalled: request stays stable.
                        pc_r    <= pc_r;
                        valid_r <= valid_r;
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= STATE_BOOT;
                    cnt_r   <= {CNT_W{1'b0}};
                    valid_r <= 1'b0;
                    pc_r    <= boot_address;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen
// Directed bench for pc_gen with BOOT_DELAY=2. Inputs change 1 time unit
// after each rising edge; outputs are checked at the same point, so each
// check sees the result of the edge just taken.
// ---------------------------------------------------------------------------
module tb_pc_gen;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        irq_i;
    logic        drq_i;
    logic        dret_i;
    logic [31:0] dret_target_i;

    pc_gen_if fetch_bus();

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    pc_gen #(.BOOT_DELAY(2)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .irq_i           (irq_i),
        .drq_i           (drq_i),
        .dret_i          (dret_i),
        .dret_target_i   (dret_target_i),
        .fetch           (fetch_bus)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic exp_valid, input logic [31:0] exp_pc);
        chk({tag, ".valid"}, {31'd0, fetch_bus.valid_o}, {31'd0, exp_valid});
        chk({tag, ".pc"}, fetch_bus.pc_o, exp_pc);
    endtask

    initial begin
        rst_i             = 1'b1;
        branch_i          = 1'b0;
        branch_target_i   = 32'h0;
        irq_i             = 1'b0;
        drq_i             = 1'b0;
        dret_i            = 1'b0;
        dret_target_i     = 32'h0;
        fetch_bus.ready_i = 1'b1;

        // Reset state, boot delay, sequential fetch
        tick();
        chk_req("reset", 1'b0, 32'h0000_0000);
        rst_i = 1'b0;
        tick();
        chk("boot_wait", {31'd0, fetch_bus.valid_o}, 32'd0);
        tick();
        chk_req("boot_first", 1'b1, 32'h0000_0000);
        tick();
        chk_req("seq_4", 1'b1, 32'h0000_0004);
        tick();
        chk_req("seq_8", 1'b1, 32'h0000_0008);

        // Back-pressure for 5 cycles with a branch pulse in the first
        fetch_bus.ready_i = 1'b0;
        branch_i          = 1'b1;
        branch_target_i   = 32'h0000_1003;
        tick();
        branch_i = 1'b0;
        chk_req("stall_0", 1'b1, 32'h0000_0008);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("stall_pc", fetch_bus.pc_o, 32'h0000_0008);
        end
        fetch_bus.ready_i = 1'b1;
        tick();
        chk_req("pend_branch", 1'b1, 32'h0000_1000);

        // irq beats a simultaneous branch; branch is dropped
        irq_i           = 1'b1;
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_2000;
        tick();
        irq_i    = 1'b0;
        branch_i = 1'b0;
        chk("irq_win", fetch_bus.pc_o, 32'hFF00_000A);
        tick();
        chk("irq_seq", fetch_bus.pc_o, 32'hFF00_000E);

        // Later branch overwrites earlier pending branch
        fetch_bus.ready_i = 1'b0;
        branch_i          = 1'b1;
        branch_target_i   = 32'h0000_3000;
        tick();
        branch_target_i = 32'h0000_4001;
        tick();
        branch_i = 1'b0;
        chk("ovr_hold", fetch_bus.pc_o, 32'hFF00_000E);
        fetch_bus.ready_i = 1'b1;
        tick();
        chk("ovr_branch", fetch_bus.pc_o, 32'h0000_4000);

        // Lower-priority branch does not displace a pending irq
        fetch_bus.ready_i = 1'b0;
        irq_i             = 1'b1;
        tick();
        irq_i           = 1'b0;
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_5000;
        tick();
        branch_i          = 1'b0;
        fetch_bus.ready_i = 1'b1;
        tick();
        chk("pend_irq_kept", fetch_bus.pc_o, 32'hFF00_000A);
        tick();
        chk("pend_irq_seq", fetch_bus.pc_o, 32'hFF00_000E);

        // Wrap at the top of the address space
        branch_i        = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        tick();
        branch_i = 1'b0;
        chk("wrap_top", fetch_bus.pc_o, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero", fetch_bus.pc_o, 32'h0000_0000);

`ifdef ECAP5_DPROC_DEBUG_EN
        // Debug entry, irq ignored, branch honoured, dret beats branch
        drq_i = 1'b1;
        tick();
        chk("dbg_enter", fetch_bus.pc_o, 32'hFF00_000B);
        irq_i = 1'b1;
        tick();
        chk("dbg_irq_ign", fetch_bus.pc_o, 32'hFF00_000F);
        irq_i           = 1'b0;
        drq_i           = 1'b0;
        branch_i        = 1'b1;
        branch_target_i = 32'h0000_6000;
        tick();
        chk("dbg_branch", fetch_bus.pc_o, 32'h0000_6000);
        dret_i          = 1'b1;
        dret_target_i   = 32'h0000_0203;
        branch_target_i = 32'h0000_7000;
        tick();
        dret_i   = 1'b0;
        branch_i = 1'b0;
        chk("dret", fetch_bus.pc_o, 32'h0000_0200);
        irq_i = 1'b1;
        tick();
        irq_i = 1'b0;
        chk("run_irq", fetch_bus.pc_o, 32'hFF00_000A);
        tick();
        chk("run_seq", fetch_bus.pc_o, 32'hFF00_000E);
`else
        // Debug inputs have no effect in the default build
        drq_i         = 1'b1;
        dret_i        = 1'b1;
        dret_target_i = 32'h0000_0200;
        tick();
        chk("nodbg_drq", fetch_bus.pc_o, 32'h0000_0004);
        drq_i  = 1'b0;
        dret_i = 1'b0;
        tick();
        chk("nodbg_seq", fetch_bus.pc_o, 32'h0000_0008);
`endif

        // Reset while stalled with a pending branch
        fetch_bus.ready_i = 1'b0;
        branch_i          = 1'b1;
        branch_target_i   = 32'h0000_9000;
        tick();
        branch_i = 1'b0;
        chk("pre_rst_valid", {31'd0, fetch_bus.valid_o}, 32'd1);
        rst_i = 1'b1;
        tick();
        chk_req("mid_rst", 1'b0, 32'h0000_0000);
        rst_i             = 1'b0;
        fetch_bus.ready_i = 1'b1;
        tick();
        chk("reboot_wait", {31'd0, fetch_bus.valid_o}, 32'd0);
        tick();
        chk_req("reboot_first", 1'b1, 32'h0000_0000);
        tick();
        chk("reboot_4", fetch_bus.pc_o, 32'h0000_0004);
        tick();
        chk("reboot_8", fetch_bus.pc_o, 32'h0000_0008);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
- REQ-001 SHALL have parameter BOOT_DELAY, default 2: number of cycles after reset release before the first request.
- REQ-002 SHALL have port clk_i, input, 1: the single clock.
- REQ-003 SHALL have port rst_i, input, 1: synchronous, active-high reset.
- REQ-004 SHALL have port branch_i, input, 1: single-cycle branch redirect pulse.
- REQ-005 SHALL have port branch_target_i, input, 32: branch target address.
- REQ-006 SHALL have port irq_i, input, 1: interrupt request, level.
- REQ-007 SHALL have port drq_i, input, 1: debug request, level.
- REQ-008 SHALL have port dret_i, input, 1: debug-return pulse.
- REQ-009 SHALL have port dret_target_i, input, 32: resume address on debug return.
- REQ-010 SHALL have port valid_o, output, 1: pc_o holds a fetch request.
- REQ-011 SHALL have port ready_i, input, 1: downstream fetch accepts the request.
- REQ-012 SHALL have port pc_o, output, 32: fetch address.

Function
- REQ-013 SHALL implement states BOOT, RUN, DEBUG.
- REQ-014 In BOOT, SHALL count BOOT_DELAY cycles with valid_o=0, then enter RUN with pc_o=boot_address and valid_o=1.
- REQ-015 SHALL complete a transfer on a cycle with valid_o=1 and ready_i=1.
- REQ-016 SHALL hold pc_o and valid_o stable while valid_o=1 and ready_i=0.
- REQ-017 After a transfer with no pending redirect, SHALL present pc_o+4 on the next cycle with valid_o=1.
- REQ-018 pc_o+4 SHALL wrap modulo 2^32, so 0xFFFFFFFC is followed by 0x00000000.
- REQ-019 Redirect priority SHALL be debug (drq_i, RUN only) > interrupt (irq_i, RUN only) > branch_i > sequential.
- REQ-020 SHALL latch any redirect arriving while a request is held into a single pending slot, applied on the cycle after the transfer.
- REQ-021 The pending slot SHALL be replaced only by an equal- or higher-priority event; a later branch SHALL overwrite an earlier branch.
- REQ-022 A redirect arriving while no request is held SHALL set pc_o on the next cycle.
- REQ-023 A debug redirect SHALL set pc_o=debug_address and enter DEBUG.
- REQ-024 An interrupt redirect SHALL set pc_o=interrupt_address.
- REQ-025 A branch redirect SHALL set pc_o={branch_target_i[31:2],2'b00}.
- REQ-026 In DEBUG, SHALL ignore irq_i and drq_i and honour branch_i.
- REQ-027 In DEBUG, dret_i SHALL redirect to {dret_target_i[31:2],2'b00} and return to RUN.
- REQ-028 A simultaneous dret_i and branch_i in DEBUG SHALL give dret_i priority.
- REQ-029 SHALL keep the pending redirect valid through back-pressure of any length.

Reset
- REQ-030 While rst_i=1, SHALL force state=BOOT, delay counter=0, pending slot cleared, valid_o=0 and pc_o=boot_address, on the next clk_i edge.
- REQ-031 rst_i asserted mid-transfer or mid-DEBUG SHALL discard all pending state, with no request issued until the BOOT delay has elapsed again.

Configuration
- REQ-032 With ECAP5_DPROC_DEBUG_EN defined, SHALL include the DEBUG state, drq_i handling and dret_i handling.
- REQ-033 Without ECAP5_DPROC_DEBUG_EN, SHALL omit the DEBUG state, ignore drq_i, dret_i and dret_target_i, and never emit debug_address.

Structure
- REQ-034 SHALL take boot_address, interrupt_address and debug_address from ecap5_dproc_pkg.
- REQ-035 SHALL add to ecap5_dproc_pkg a pc_gen state enum (BOOT, RUN, DEBUG) and a redirect-cause enum (NONE, BRANCH, IRQ, DEBUG, DRET).
- REQ-036 SHALL place priority selection and pending-slot update in one sub-module, pc_redirect_arb.

Verification
- REQ-037 Reset, then ready_i=1 -> valid_o=0 for 2 cycles, then pc_o = 0x00000000, 0x00000004, 0x00000008.
- REQ-038 ready_i=0 for 5 cycles with a branch_i pulse to 0x00001003 -> pc_o unchanged; after the transfer, pc_o=0x00001000.
- REQ-039 Same cycle irq_i=1 and branch_i=1 -> pc_o=0xFF00000A; branch discarded.
- REQ-040 drq_i=1 -> pc_o=0xFF00000B; irq_i then ignored; dret_i with target 0x00000200 -> pc_o=0x00000200, state RUN.
- REQ-041 pc_o=0xFFFFFFFC transferred -> next pc_o=0x00000000.
- REQ-042 rst_i pulsed while valid_o=1 with a branch pending -> valid_o=0 for 2 cycles, then pc_o=0x00000000; pending branch never appears.
